// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_e;

    // A byte address is misaligned when either of its two low bits is set.
    function automatic logic dmem_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, registered synchronous read.
// Contents and the read register are deliberately not reset.
module dmem_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // One access per enabled cycle; a store does not disturb the read register.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states,
// one ACCESS cycle, then a one-cycle response pulse.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flag and suppress misaligned
// accesses with resp_err).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [DMEM_WORD_W-1:0] req_addr,
    input  logic [DMEM_WORD_W-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [DMEM_WORD_W-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   busy
);

    localparam logic [DMEM_CNT_W-1:0] WAIT_CNT = DMEM_CNT_W'(WAIT_CYCLES);

    dmem_state_e             state, nstate;
    logic [DMEM_CNT_W-1:0]   cnt;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [DMEM_WORD_W-1:0]  lat_wdata;
    logic                    lat_bad;
    logic                    bad_in;
    logic                    rd_sel;
    logic                    accept;
    logic                    ram_en;
    logic [DMEM_WORD_W-1:0]  ram_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad_in = dmem_misaligned(req_addr[1:0]);
`else
    assign bad_in = 1'b0;
`endif

    assign accept     = (state == IDLE) && req_valid;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state == WAIT) || (state == RESP);
    // Misaligned accesses never touch the array.
    assign ram_en     = (state == ACCESS) && !lat_bad;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state decode.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:   if (req_valid) nstate = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            WAIT:   if (cnt <= DMEM_CNT_W'(1)) nstate = ACCESS;
            ACCESS: nstate = RESP;
            RESP:   nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Wait-state counter: loaded on acceptance, counts down in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              cnt <= '0;
        else if (accept)         cnt <= WAIT_CNT;
        else if (state == WAIT)  cnt <= cnt - DMEM_CNT_W'(1);
    end

    // Request capture; inputs are ignored outside IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_bad   <= 1'b0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_idx   <= req_addr[ADDR_WIDTH+1:2];
            lat_wdata <= req_wdata;
            lat_bad   <= bad_in;
        end
    end

    // Read-data select: the RAM read register holds the load word, this flag
    // decides whether the response shows it or zero (store / misaligned).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                rd_sel <= 1'b0;
        else if (state == ACCESS)  rd_sel <= !lat_write && !lat_bad;
    end

    assign resp_rdata = rd_sel ? ram_rdata : '0;

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;

    // Error flag captured alongside the access, held until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                err_q <= 1'b0;
        else if (state == ACCESS)  err_q <= lat_bad;
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    dmem_ram #(
        .AW (ADDR_WIDTH),
        .DW (DMEM_WORD_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (lat_write),
        .addr  (lat_idx),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the ARM core's load/store port. Accepts one word request at a time over a valid/ready handshake, then inserts a programmable number of wait states. It commits the write or captures the read data, and returns a one-cycle response pulse. It lets the processor be exercised against memory with realistic latency instead of a zero-delay array.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-index width; memory holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states between request acceptance and memory access; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load data; valid while resp_valid is high.
- resp_err  output  1  misaligned-access flag, qualified by resp_valid.
- busy  output  1  high in WAIT or RESP.

## Operation
States:
- IDLE:
  - req_ready=1.
  - On req_valid: latch write, addr, wdata. Load the counter with WAIT_CYCLES.
  - Go to WAIT, or go directly to ACCESS if WAIT_CYCLES=0.
- WAIT: decrement the counter. When the counter is 1, go to ACCESS.
- ACCESS (one cycle):
  - Store: the RAM write commits at the end of this cycle.
  - Load: RAM data is registered into resp_rdata at the end of this cycle.
  - Go to RESP.
- RESP (one cycle):
  - resp_valid=1. No backpressure: the requester must take the response.
  - Go to IDLE.

Data and addressing rules:
- Word index is req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+2).
- Store response: resp_rdata=0.
- resp_rdata holds its value outside RESP.
- resp_err is 0 except as defined under Configuration.
- req_valid, req_write, req_addr and req_wdata are ignored outside IDLE.
- Counter width is 4 bits. It does not wrap because it is loaded only in IDLE.

## Timing
Reset values (while reset is low):
- state=IDLE, counter=0.
- resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- req_ready=1, decoded from state.
- RAM contents are not reset.

Latency, with the handshake in cycle 0:
- ACCESS is cycle WAIT_CYCLES+1.
- resp_valid is high in cycle WAIT_CYCLES+2.
- req_ready is high again in cycle WAIT_CYCLES+3.
- Throughput: one request per WAIT_CYCLES+3 cycles.

Boundary conditions:
- A store followed by a load to the same word returns the new data, because the store commits in ACCESS before the load is accepted.
- Reset asserted mid-transaction aborts it. A store not yet in ACCESS is not committed, and no response is issued.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A request with req_addr[1:0]!=0 completes with normal latency and resp_err=1 in RESP.
  - The store is suppressed and the load returns resp_rdata=0.
- DMEM_ALIGN_CHECK_EN undefined:
  - req_addr[1:0] is ignored.
  - resp_err is tied to 0.

## Structure
- Package dmem_pkg:
  - State enum: IDLE, WAIT, ACCESS, RESP.
  - DMEM_WORD_W=32.
  - DMEM_CNT_W=4.
- Sub-module dmem_ram:
  - Single-port array with synchronous write and synchronous read.
  - Enable is driven in ACCESS.
  - The FSM, counter and response registers stay in dmem_responder.

## Test plan
- Reset: hold reset low for 3 cycles mid-WAIT after a store of 0xDEADBEEF to 0x10 -> no resp_valid pulse; reading 0x10 afterward returns the prior contents.
- Store/load, WAIT_CYCLES=2: store 0x12345678 to 0x40, then load 0x40 -> each resp_valid arrives exactly 4 cycles after its handshake; load resp_rdata=0x12345678.
- Zero wait, WAIT_CYCLES=0: back-to-back loads -> resp_valid in cycle 2 and req_ready every 3rd cycle.
- Aliasing, ADDR_WIDTH=8: store 0xA5A5A5A5 to 0x000 -> load 0x400 returns 0xA5A5A5A5.
- Ignored inputs: toggle req_valid and req_addr during WAIT -> no extra handshake; the response matches the latched request.
- Misalignment: store 0x1 to 0x42, then load 0x40.
  - DMEM_ALIGN_CHECK_EN defined: resp_err=1 on the store; the load returns the old word.
  - DMEM_ALIGN_CHECK_EN undefined: resp_err=0; the load returns 0x1.
